// File: rtl/fixed_to_float.sv
// Signed fixed point to FP16, one normalize shift per cycle; out_valid at accept+shift+2 (zero: +1).
// Single operation in flight, in_ready only in IDLE; result held until out_ready. FIXED_TO_FLOAT_ROUND_NEAREST_EN selects RNE over truncation.
module fixed_to_float #(
  parameter int IN_W      = 16,
  parameter int FRAC_BITS = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [15:0]     out_data
);

  typedef enum logic [1:0] {IDLE, NORM, PACK, DONE} state_t;

  // Exponent before subtracting the normalize shift: (IN_W-1) - FRAC_BITS + bias 15.
  localparam int EXP_BASE = IN_W + 14 - FRAC_BITS;

  state_t            state_q, state_d;
  logic              sign_q, sign_d;
  logic [IN_W-1:0]   mag_q, mag_d;
  logic [5:0]        shift_q, shift_d;
  logic              out_valid_q, out_valid_d;
  logic [15:0]       out_data_q, out_data_d;

  logic [IN_W-1:0]   mag_in;
  logic signed [8:0] exp_raw, exp_rnd;
  logic [9:0]        mant_raw, mant_rnd;
  logic              carry;
  logic [15:0]       packed_w;

`ifdef FIXED_TO_FLOAT_ROUND_NEAREST_EN
  localparam logic [IN_W-1:0] STICKY_MASK = IN_W'((64'd1 << (IN_W - 12)) - 64'd1);
  logic guard, sticky, inc;
`endif

  // The most negative input negates to 2^(IN_W-1), which still fits unsigned.
  assign mag_in = in_data[IN_W-1] ? (~in_data + IN_W'(1)) : in_data;

  always_comb begin
    exp_raw  = 9'(EXP_BASE) - 9'(shift_q);
    mant_raw = mag_q[IN_W-2 -: 10];
`ifdef FIXED_TO_FLOAT_ROUND_NEAREST_EN
    guard  = mag_q[IN_W-12];
    sticky = |(mag_q & STICKY_MASK);
    inc    = guard & (sticky | mant_raw[0]);
    {carry, mant_rnd} = {1'b0, mant_raw} + 11'(inc);
`else
    carry    = 1'b0;
    mant_rnd = mant_raw;
`endif
    exp_rnd = exp_raw + 9'(carry);
    if (exp_rnd <= 9'sd0) begin
      packed_w = 16'h0000;
    end else if (exp_rnd >= 9'sd31) begin
      packed_w = {sign_q, 5'h1E, 10'h3FF};
    end else begin
      packed_w = {sign_q, exp_rnd[4:0], mant_rnd};
    end
  end

  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    mag_d       = mag_q;
    shift_d     = shift_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = in_data[IN_W-1];
          mag_d   = mag_in;
          shift_d = '0;
          if (mag_in == '0) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            out_data_d  = 16'h0000;
          end else begin
            state_d = NORM;
          end
        end
      end
      NORM: begin
        if (mag_q[IN_W-1]) begin
          state_d = PACK;
        end else begin
          mag_d   = mag_q << 1;
          shift_d = shift_q + 6'd1;
        end
      end
      PACK: begin
        out_data_d  = packed_w;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      mag_q       <= '0;
      shift_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 16'h0000;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      mag_q       <= mag_d;
      shift_q     <= shift_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_fixed_to_float.sv
// Directed vectors for fixed_to_float across four parameterisations, plus backpressure and mid-conversion reset.
module tb_fixed_to_float;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic out_ready = 1'b0;

  logic        m_in_valid = 1'b0, m_in_ready, m_out_valid;
  logic [15:0] m_in_data = '0, m_out_data;
  logic        a_in_valid = 1'b0, a_in_ready, a_out_valid;
  logic [15:0] a_in_data = '0, a_out_data;
  logic        b_in_valid = 1'b0, b_in_ready, b_out_valid;
  logic [15:0] b_in_data = '0, b_out_data;
  logic        c_in_valid = 1'b0, c_in_ready, c_out_valid;
  logic [31:0] c_in_data = '0;
  logic [15:0] c_out_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fixed_to_float #(.IN_W(16), .FRAC_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(m_in_valid), .in_ready(m_in_ready), .in_data(m_in_data),
    .out_valid(m_out_valid), .out_ready(out_ready), .out_data(m_out_data));
  fixed_to_float #(.IN_W(16), .FRAC_BITS(20)) dut_f20 (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data));
  fixed_to_float #(.IN_W(16), .FRAC_BITS(0)) dut_f0 (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data));
  fixed_to_float #(.IN_W(32), .FRAC_BITS(0)) dut_w32 (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
    .out_valid(c_out_valid), .out_ready(out_ready), .out_data(c_out_data));

  typedef struct {
    int          w;
    logic [31:0] din;
    logic [15:0] e_tr;
    logic [15:0] e_rn;
    int          lat;
  } vec_t;

  vec_t tv[17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_in(input int w, input logic v, input logic [31:0] d);
    case (w)
      0: begin m_in_valid = v; m_in_data = d[15:0]; end
      1: begin a_in_valid = v; a_in_data = d[15:0]; end
      2: begin b_in_valid = v; b_in_data = d[15:0]; end
      default: begin c_in_valid = v; c_in_data = d; end
    endcase
  endtask

  function automatic logic ov(input int w);
    case (w)
      0: return m_out_valid;
      1: return a_out_valid;
      2: return b_out_valid;
      default: return c_out_valid;
    endcase
  endfunction

  function automatic logic [15:0] od(input int w);
    case (w)
      0: return m_out_data;
      1: return a_out_data;
      2: return b_out_data;
      default: return c_out_data;
    endcase
  endfunction

  function automatic logic ir(input int w);
    case (w)
      0: return m_in_ready;
      1: return a_in_ready;
      2: return b_in_ready;
      default: return c_in_ready;
    endcase
  endfunction

  // Accept on edge 0, return the edge index where out_valid is first seen (-1 on timeout).
  task automatic start_and_wait(input int w, input logic [31:0] din, output int lat);
    lat = -1;
    @(negedge clk);
    drive_in(w, 1'b1, din);
    @(posedge clk);
    #1 drive_in(w, 1'b0, din);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (ov(w)) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run(input int w, input logic [31:0] din, input logic [15:0] exp_d,
                     input int exp_lat, input string nm);
    int lat;
    start_and_wait(w, din, lat);
    chk({nm, "_latency"}, lat, exp_lat);
    chk({nm, "_data"}, od(w), exp_d);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk({nm, "_in_ready_after"}, ir(w), 1'b1);
    chk({nm, "_out_valid_after"}, ov(w), 1'b0);
  endtask

  initial begin
    int   lat;
    logic [15:0] exp_d;

    tv[0]  = '{0, 32'h0000_0100, 16'h3C00, 16'h3C00, 9};
    tv[1]  = '{0, 32'h0000_FF00, 16'hBC00, 16'hBC00, 9};
    tv[2]  = '{0, 32'h0000_8000, 16'hD800, 16'hD800, 2};
    tv[3]  = '{0, 32'h0000_0000, 16'h0000, 16'h0000, 1};
    tv[4]  = '{0, 32'h0000_7FFF, 16'h57FF, 16'h5800, 3};
    tv[5]  = '{0, 32'h0000_0001, 16'h1C00, 16'h1C00, 17};
    tv[6]  = '{0, 32'h0000_0180, 16'h3E00, 16'h3E00, 9};
    tv[7]  = '{0, 32'h0000_FE80, 16'hBE00, 16'hBE00, 9};
    tv[8]  = '{0, 32'h0000_1234, 16'h4C8D, 16'h4C8D, 5};
    tv[9]  = '{0, 32'h0000_4008, 16'h5400, 16'h5400, 3};
    tv[10] = '{0, 32'h0000_4018, 16'h5401, 16'h5402, 3};
    tv[11] = '{0, 32'h0000_FFFF, 16'h9C00, 16'h9C00, 17};
    tv[12] = '{1, 32'h0000_0001, 16'h0000, 16'h0000, 17};
    tv[13] = '{2, 32'h0000_7FFF, 16'h77FF, 16'h7800, 3};
    tv[14] = '{3, 32'h8000_0000, 16'hFBFF, 16'hFBFF, 2};
    tv[15] = '{3, 32'h0000_0001, 16'h3C00, 16'h3C00, 33};
    tv[16] = '{3, 32'h7FFF_FFFF, 16'h7BFF, 16'h7BFF, 3};

    #12;
    chk("reset_out_valid", m_out_valid, 1'b0);
    chk("reset_out_data", m_out_data, 16'h0000);
    chk("reset_in_ready", m_in_ready, 1'b1);
    chk("reset_w32_out_data", c_out_data, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
`ifdef FIXED_TO_FLOAT_ROUND_NEAREST_EN
      exp_d = tv[i].e_rn;
`else
      exp_d = tv[i].e_tr;
`endif
      run(tv[i].w, tv[i].din, exp_d, tv[i].lat, $sformatf("vec%0d", i));
    end

    // Backpressure: result held for 5 cycles, a stray in_valid pulse is ignored.
    start_and_wait(0, 32'h0100, lat);
    chk("bp_latency", lat, 9);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) drive_in(0, 1'b1, 32'h8000);
      if (i == 2) drive_in(0, 1'b0, 32'h0000);
      @(posedge clk);
      #1;
      chk($sformatf("bp_hold_data%0d", i), m_out_data, 16'h3C00);
      chk($sformatf("bp_hold_valid%0d", i), m_out_valid, 1'b1);
      chk($sformatf("bp_hold_in_ready%0d", i), m_in_ready, 1'b0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("bp_release_in_ready", m_in_ready, 1'b1);
    chk("bp_release_out_valid", m_out_valid, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_pulse_ignored_valid", m_out_valid, 1'b0);
    chk("bp_pulse_ignored_ready", m_in_ready, 1'b1);

    // Reset while normalizing discards the conversion and clears the output at once.
    @(negedge clk);
    drive_in(0, 1'b1, 32'h0001);
    @(posedge clk);
    #1 drive_in(0, 1'b0, 32'h0000);
    repeat (3) @(posedge clk);
    #1;
    chk("mid_norm_busy", m_in_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", m_out_valid, 1'b0);
    chk("rst_out_data", m_out_data, 16'h0000);
    chk("rst_in_ready", m_in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    run(0, 32'h0100, 16'h3C00, 9, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
